// File: rtl/plot_framebuffer.sv
// rtl/plot_framebuffer.sv - 160x120x3 plot framebuffer with raster readout stream
// Optional sticky out-of-range plot flag enabled by defining PLOT_OOB_FLAG_EN.
module plot_framebuffer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vga_x,
  input  logic [6:0] vga_y,
  input  logic [2:0] vga_colour,
  input  logic       vga_plot,
  input  logic       scan_start,
  input  logic       scan_ready,
  output logic       pix_valid,
  output logic [2:0] pix_colour,
  output logic [7:0] pix_x,
  output logic [6:0] pix_y,
  output logic       pix_last,
  output logic       scan_busy,
  output logic       scan_done,
  output logic       oob_err
);

  localparam int unsigned DEPTH = 160 * 120;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT, S_DONE} state_t;

  state_t      r_state;
  logic [7:0]  r_x;
  logic [6:0]  r_y;
  logic        r_pix_valid;
  logic        r_pix_last;
  logic        r_busy;
  logic        r_done;
  logic [2:0]  r_rd_data;
  logic [2:0]  r_mem [0:DEPTH-1];

  logic        w_wr_in_range;
  logic        w_wr_en;
  logic [14:0] w_wr_addr;
  logic [14:0] w_rd_addr;
  logic        w_at_end;

  assign w_wr_in_range = (vga_x < 8'd160) && (vga_y < 7'd120);
  assign w_wr_en       = vga_plot && w_wr_in_range;
  assign w_wr_addr     = ({8'd0, vga_y} << 7) + ({8'd0, vga_y} << 5) + {7'd0, vga_x};
  assign w_rd_addr     = ({8'd0, r_y} << 7) + ({8'd0, r_y} << 5) + {7'd0, r_x};
  assign w_at_end      = (r_x == 8'd159) && (r_y == 7'd119);

  // Array has no reset; a same-address write lands after the read samples the old value.
  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[w_wr_addr] <= vga_colour;
    if (r_state == S_FETCH)
      r_rd_data <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_x         <= 8'd0;
      r_y         <= 7'd0;
      r_pix_valid <= 1'b0;
      r_pix_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (scan_start) begin
            r_x     <= 8'd0;
            r_y     <= 7'd0;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_pix_valid <= 1'b1;
          r_pix_last  <= w_at_end;
          r_state     <= S_PRESENT;
        end
        S_PRESENT: begin
          if (scan_ready) begin
            r_pix_valid <= 1'b0;
            r_pix_last  <= 1'b0;
            if (r_pix_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              if (r_x == 8'd159) begin
                r_x <= 8'd0;
                r_y <= r_y + 7'd1;
              end else begin
                r_x <= r_x + 8'd1;
              end
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gating on valid gives a zero colour the instant reset asserts.
  assign pix_colour = r_pix_valid ? r_rd_data : 3'd0;
  assign pix_valid  = r_pix_valid;
  assign pix_x      = r_x;
  assign pix_y      = r_y;
  assign pix_last   = r_pix_last;
  assign scan_busy  = r_busy;
  assign scan_done  = r_done;

`ifdef PLOT_OOB_FLAG_EN
  logic r_oob;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_oob <= 1'b0;
    else if (vga_plot && !w_wr_in_range)
      r_oob <= 1'b1;
  end

  assign oob_err = r_oob;
`else
  assign oob_err = 1'b0;
`endif

endmodule

// File: doc/plot_framebuffer.md
PLOT_FRAMEBUFFER -- requirements
Module: plot_framebuffer

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: vga_x  in  8, vga_y  in  7, vga_colour  in  3, vga_plot  in  1  plot write port.
REQ-004 SHALL have ports: scan_start  in  1  request a full-frame readout.
REQ-005 SHALL have ports: pix_valid  out  1, pix_colour  out  3, pix_x  out  8, pix_y  out  7, pix_last  out  1  readout stream.
REQ-006 SHALL have port: scan_ready  in  1  consumer accepts the pixel when pix_valid && scan_ready.
REQ-007 SHALL have ports: scan_busy  out  1, scan_done  out  1, oob_err  out  1.

Function
REQ-010 SHALL hold a 160x120 array of 3-bit pixels; address = y*160 + x, 15 bits, computed as (y<<7)+(y<<5)+x.
REQ-011 SHALL write vga_colour at (vga_x, vga_y) on the rising clk edge where vga_plot=1 and vga_x<160 and vga_y<120.
REQ-012 SHALL drop plots with vga_x>=160 or vga_y>=120; no array location changes.
REQ-013 SHALL accept a plot every cycle, independent of scan state; no backpressure on the plot port.
REQ-014 Scan FSM states: IDLE, FETCH, PRESENT, DONE.
REQ-015 IDLE: scan_start=1 -> FETCH with scan counters (x,y)=(0,0); scan_start in any other state SHALL be ignored.
REQ-016 FETCH: drives the read address of the current (x,y); next cycle -> PRESENT (1-cycle registered read latency).
REQ-017 PRESENT: pix_valid=1; pix_colour, pix_x, pix_y, pix_last SHALL hold stable until the handshake.
REQ-018 PRESENT with scan_ready=1: advance raster order, x inner 0..159, y outer 0..119; x=159 wraps to 0 and increments y; -> FETCH.
REQ-019 pix_last=1 only for (159,119); its handshake -> DONE instead of FETCH.
REQ-020 DONE: scan_done=1 for exactly one cycle, then -> IDLE.
REQ-021 scan_busy=1 in FETCH, PRESENT and DONE; 0 in IDLE.
REQ-022 Simultaneous plot and scan read to the same address in one cycle: read returns the old value (read-before-write); the new value is visible to any later read.
REQ-023 Throughput: one pixel per 2 cycles with scan_ready tied high; a full frame takes 38400 cycles from FETCH entry to DONE.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE; pix_valid, pix_last, scan_busy, scan_done, oob_err = 0; pix_colour, pix_x, pix_y = 0; scan counters = 0.
REQ-031 Array contents SHALL NOT be reset; they are undefined until written.
REQ-032 Reset asserted mid-scan SHALL abort the scan; no scan_done is produced for the aborted scan.
REQ-033 After reset release, the first scan_start SHALL be honoured on the first rising edge.

Configuration
REQ-040 Macro PLOT_OOB_FLAG_EN defined: oob_err is sticky; it is set on the edge following any dropped plot (REQ-012) and is cleared only by reset.
REQ-041 Macro PLOT_OOB_FLAG_EN undefined: oob_err is tied 0; out-of-range plots are still dropped.

Verification
REQ-050 Reset, plot (3,2)=3'b101 and (159,119)=3'b010, scan with scan_ready=1 -> pixel index 323 has colour 5 at x=3,y=2; final pixel has colour 2, pix_last=1; scan_done pulses once.
REQ-051 Fill all 19200 pixels with colour = x[2:0] via plots, then scan with scan_ready toggled randomly -> every accepted pixel has colour == pix_x[2:0]; outputs stay stable while scan_ready=0; exactly 19200 handshakes.
REQ-052 Plot (160,0)=7 and (0,120)=7 -> (0,0) and (159,0) are unchanged; with PLOT_OOB_FLAG_EN, oob_err=1 and stays 1 until reset; without it, oob_err=0.
REQ-053 During a scan, plot (10,0)=6 in the same cycle FETCH reads (10,0) -> streamed value is the old one; a second scan returns 6.
REQ-054 Assert rst_n=0 while PRESENT at (50,40) -> pix_valid=0 and scan_busy=0 immediately; no scan_done; a new scan_start restarts at (0,0).
REQ-055 Pulse scan_start during a busy scan -> ignored; exactly one scan_done and one 19200-pixel frame.
